// File: rtl/prefix_channel_arbiter.sv
// Round-robin arbiter that shares one registered valid/ready channel between NUM_REQ requesters; 1-cycle accept-to-valid latency.
// Backpressure: while the output slice is full and some_prefix_ready is low, every req_ready is held low.
module prefix_channel_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    localparam int SW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_bits_data_0,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_bits_data_1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_bits_data_2,
    output logic                          some_prefix_valid,
    input  logic                          some_prefix_ready,
    output logic [DATA_WIDTH-1:0]         some_prefix_bits_data_0,
    output logic [DATA_WIDTH-1:0]         some_prefix_bits_data_1,
    output logic [DATA_WIDTH-1:0]         some_prefix_bits_data_2,
    output logic [SW-1:0]                 some_prefix_src,
    output logic [CNT_WIDTH-1:0]          xfer_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slice_state_t;

    slice_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [DATA_WIDTH-1:0] data2_q, data2_d;
    logic [SW-1:0]         src_q, src_d;
    logic [SW-1:0]         ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  load_en;
    logic                  any_req;
    logic                  accept;
    logic [SW-1:0]         winner;
    logic [DATA_WIDTH-1:0] sel0, sel1, sel2;

    // Scan offsets from the highest down so the lowest offset from ptr wins.
    always_comb begin
        int idx;
        idx     = 0;
        winner  = '0;
        any_req = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[SW'(idx)]) begin
                winner  = SW'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign load_en = (state_q == EMPTY) || some_prefix_ready;
    assign accept  = load_en && any_req;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        sel0 = '0;
        sel1 = '0;
        sel2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (SW'(i) == winner) begin
                sel0 = req_bits_data_0[i*DATA_WIDTH +: DATA_WIDTH];
                sel1 = req_bits_data_1[i*DATA_WIDTH +: DATA_WIDTH];
                sel2 = req_bits_data_2[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data0_d = data0_q;
        data1_d = data1_q;
        data2_d = data2_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = FULL;
            data0_d = sel0;
            data1_d = sel1;
            data2_d = sel2;
            src_d   = winner;
            ptr_d   = (winner == SW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end else if (load_en) begin
            state_d = EMPTY;
        end
        if ((state_q == FULL) && some_prefix_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            data0_q <= '0;
            data1_q <= '0;
            data2_q <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign some_prefix_valid       = (state_q == FULL);
    assign some_prefix_bits_data_0 = data0_q;
    assign some_prefix_bits_data_1 = data1_q;
    assign some_prefix_bits_data_2 = data2_q;
    assign some_prefix_src         = src_q;
    assign xfer_count              = cnt_q;

endmodule

// File: tb/tb_prefix_channel_arbiter.sv
// Bench for prefix_channel_arbiter: directed steps plus random traffic against a behavioural model.
module tb_prefix_channel_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] d0, d1, d2;
    logic            some_prefix_valid;
    logic            some_prefix_ready;
    logic [DW-1:0]   o0, o1, o2;
    logic [1:0]      src;
    logic [CW-1:0]   xfer_count;

    int checks = 0;
    int errors = 0;

    // Reference model: slice contents, round-robin pointer, handshake count.
    bit      m_full;
    int      m_src, m_ptr, m_cnt;
    int      m_d0, m_d1, m_d2;

    prefix_channel_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_bits_data_0         (d0),
        .req_bits_data_1         (d1),
        .req_bits_data_2         (d2),
        .some_prefix_valid       (some_prefix_valid),
        .some_prefix_ready       (some_prefix_ready),
        .some_prefix_bits_data_0 (o0),
        .some_prefix_bits_data_1 (o1),
        .some_prefix_bits_data_2 (o2),
        .some_prefix_src         (src),
        .xfer_count              (xfer_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_out();
        chk("valid", 32'(some_prefix_valid), 32'(m_full));
        chk("count", 32'(xfer_count), m_cnt);
        if (m_full) begin
            chk("data0", 32'(o0), m_d0);
            chk("data1", 32'(o1), m_d1);
            chk("data2", 32'(o2), m_d2);
            chk("src", 32'(src), m_src);
        end
    endtask

    // Called just after a posedge with inputs already applied.
    task automatic cycle();
        int           w;
        bit           le;
        logic [N-1:0] exp_rr;
        #1;
        le     = !m_full || some_prefix_ready;
        w      = pick();
        exp_rr = (le && w >= 0) ? (N'(1) << w) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rr));
        @(posedge clock);
        if (m_full && some_prefix_ready) m_cnt = (m_cnt + 1) % (1 << CW);
        if (le && w >= 0) begin
            m_full = 1'b1;
            m_d0   = int'(d0[w*DW +: DW]);
            m_d1   = int'(d1[w*DW +: DW]);
            m_d2   = int'(d2[w*DW +: DW]);
            m_src  = w;
            m_ptr  = (w + 1) % N;
        end else if (le) begin
            m_full = 1'b0;
        end
        #1;
        check_out();
    endtask

    task automatic drive(input logic [N-1:0] v, input logic r);
        req_valid         = v;
        some_prefix_ready = r;
    endtask

    task automatic rand_data();
        d0 = $urandom;
        d1 = $urandom;
        d2 = $urandom;
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_src  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
        m_d0   = 0;
        m_d1   = 0;
        m_d2   = 0;
    endtask

    // Asserted between clock edges so the clear must be asynchronous.
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #2;
        chk("rst_valid", 32'(some_prefix_valid), 0);
        chk("rst_count", 32'(xfer_count), 0);
        chk("rst_src", 32'(src), 0);
        chk("rst_data0", 32'(o0), 0);
        reset = 1'b0;
    endtask

    initial begin
        int c0;
        reset = 1'b1;
        model_reset();
        drive('0, 1'b0);
        d0 = '0;
        d1 = '0;
        d2 = '0;
        #3;
        chk("t1_valid", 32'(some_prefix_valid), 0);
        chk("t1_count", 32'(xfer_count), 0);
        chk("t1_req_ready", 32'(req_ready), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // All requesters active: grants rotate 0,1,2,3,...
        drive(4'hF, 1'b1);
        for (int k = 0; k < 8; k++) begin
            rand_data();
            cycle();
            chk("t2_src_seq", 32'(src), k % 4);
        end
        drive('0, 1'b1);
        cycle();
        chk("t2_count", 32'(xfer_count), 8);

        // Stall with a held beat from requester 2.
        d0 = 32'h0011_0000;
        d1 = 32'h0022_0000;
        d2 = 32'h0033_0000;
        drive(4'b0100, 1'b1);
        cycle();
        chk("t3_d0", 32'(o0), 32'h11);
        chk("t3_d1", 32'(o1), 32'h22);
        chk("t3_d2", 32'(o2), 32'h33);
        chk("t3_src", 32'(src), 2);
        drive(4'hF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            rand_data();
            cycle();
            chk("t3_hold_d0", 32'(o0), 32'h11);
            chk("t3_hold_rr", 32'(req_ready), 0);
        end
        c0 = int'(xfer_count);
        drive('0, 1'b1);
        cycle();
        chk("t3_one_hs", 32'(xfer_count), (c0 + 1) % 256);
        chk("t3_empty", 32'(some_prefix_valid), 0);

        // ptr is 3 here.
        drive(4'b1001, 1'b1);
        cycle();
        chk("t4_grant3", 32'(src), 3);
        cycle();
        chk("t4_grant0", 32'(src), 0);
        drive(4'b0001, 1'b1);
        cycle();
        chk("t4_wrap0", 32'(src), 0);
        drive('0, 1'b1);
        cycle();

        // Counter wrap.
        do_reset();
        drive(4'hF, 1'b1);
        for (int k = 0; k < 257; k++) begin
            rand_data();
            cycle();
        end
        drive('0, 1'b1);
        cycle();
        chk("t5_wrap", 32'(xfer_count), 1);

        // Reset while full and stalled, pointer left at 2.
        rand_data();
        drive(4'b0010, 1'b0);
        cycle();
        drive('0, 1'b0);
        cycle();
        chk("t6_full", 32'(some_prefix_valid), 1);
        do_reset();
        drive(4'hF, 1'b1);
        rand_data();
        cycle();
        chk("t6_first0", 32'(src), 0);

        for (int k = 0; k < 400; k++) begin
            drive(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            rand_data();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
